iq_capture_sequencer: RTL

Run-level controller for the IQ capture HLS core: accepts a capture request, drives the core's ap_ctrl_hs handshake, and counts output beats to the requested length. It supervises the run with a beat watchdog and the registered deadlock flag from the core's dataflow deadlock monitor. On any fault it pulses a core reset and reports a status code. It sits between the AXI-Lite register bank and the capture core.

---
 rtl/iq_capture_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/iq_capture_sequencer.sv
// rtl/iq_capture_sequencer.sv - run-level controller for the IQ capture core
// Drives ap_ctrl_hs, counts output beats and recovers the core on abort/deadlock/timeout.
module iq_capture_sequencer #(
  parameter int CNT_W      = 32,
  parameter int WDOG_W     = 24,
  parameter int RST_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [WDOG_W-1:0] cfg_wdog,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  input  logic              dl_block,
  input  logic              beat_valid,
  input  logic              beat_ready,
  output logic              core_rst,
  output logic              busy,
  output logic              done_pulse,
  output logic [2:0]        status,
  output logic [CNT_W-1:0]  beats
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES - 1);

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_ABORT    = 3'd1;
  localparam logic [2:0] ST_DEADLOCK = 3'd2;
  localparam logic [2:0] ST_TIMEOUT  = 3'd3;
  localparam logic [2:0] ST_BADLEN   = 3'd4;

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, RECOVER, DONE} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  len_latched, len_latched_next;
  logic [WDOG_W-1:0] wdog_reload, wdog_reload_next;
  logic [WDOG_W-1:0] wdog_count, wdog_count_next;
  logic [CNT_W-1:0]  beats_next;
  logic [2:0]        code, code_next;
  logic [2:0]        status_next;
  logic [RC_W-1:0]   rst_count, rst_count_next;

  logic              beat;
  logic              wdog_en;
  logic              wdog_zero;
  logic              fault;
  logic [2:0]        fault_code;
  logic [CNT_W-1:0]  beats_inc;

  assign beat      = beat_valid & beat_ready;
  assign wdog_en   = (wdog_reload != '0);
  assign wdog_zero = wdog_en && (wdog_count == '0);
  assign beats_inc = beats + CNT_W'(1);

  // Fault priority shared by START (abort only), RUN and DRAIN.
  always_comb begin
    fault      = 1'b1;
    fault_code = ST_OK;
    if (cfg_abort) begin
      fault_code = ST_ABORT;
    end else if (dl_block) begin
      fault_code = ST_DEADLOCK;
    end else if (wdog_zero) begin
      fault_code = ST_TIMEOUT;
    end else begin
      fault = 1'b0;
    end
  end

  always_comb begin
    state_next       = state;
    len_latched_next = len_latched;
    wdog_reload_next = wdog_reload;
    wdog_count_next  = wdog_count;
    beats_next       = beats;
    code_next        = code;
    rst_count_next   = rst_count;
    status_next      = status;

    case (state)
      IDLE: begin
        if (cfg_start) begin
          if (cfg_len == '0) begin
            code_next  = ST_BADLEN;
            state_next = DONE;
          end else if (ap_idle) begin
            len_latched_next = cfg_len;
            wdog_reload_next = cfg_wdog;
            wdog_count_next  = cfg_wdog;
            beats_next       = '0;
            code_next        = ST_OK;
            state_next       = START;
          end
        end
      end

      START: begin
        if (cfg_abort) begin
          code_next      = ST_ABORT;
          rst_count_next = RC_LOAD;
          state_next     = RECOVER;
        end else if (ap_ready) begin
          state_next = RUN;
        end
      end

      RUN: begin
        if (beat) begin
          beats_next      = beats_inc;
          wdog_count_next = wdog_reload;
        end else if (wdog_en && (wdog_count != '0)) begin
          wdog_count_next = wdog_count - WDOG_W'(1);
        end
        // A beat landing on a fault cycle is still counted.
        if (beat && (beats_inc == len_latched)) begin
          state_next = DRAIN;
        end else if (fault) begin
          code_next      = fault_code;
          rst_count_next = RC_LOAD;
          state_next     = RECOVER;
        end
      end

      DRAIN: begin
        if (wdog_en && (wdog_count != '0)) begin
          wdog_count_next = wdog_count - WDOG_W'(1);
        end
        if (ap_done) begin
          code_next  = ST_OK;
          state_next = DONE;
        end else if (fault) begin
          code_next      = fault_code;
          rst_count_next = RC_LOAD;
          state_next     = RECOVER;
        end
      end

      RECOVER: begin
        if (rst_count == '0) begin
          state_next = DONE;
        end else begin
          rst_count_next = rst_count - RC_W'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (state_next == DONE) begin
      status_next = code_next;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      len_latched <= '0;
      wdog_reload <= '0;
      wdog_count  <= '0;
      beats       <= '0;
      code        <= ST_OK;
      status      <= ST_OK;
      rst_count   <= '0;
      ap_start    <= 1'b0;
      core_rst    <= 1'b0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      state       <= state_next;
      len_latched <= len_latched_next;
      wdog_reload <= wdog_reload_next;
      wdog_count  <= wdog_count_next;
      beats       <= beats_next;
      code        <= code_next;
      status      <= status_next;
      rst_count   <= rst_count_next;
      ap_start    <= (state_next == START);
      core_rst    <= (state_next == RECOVER);
      busy        <= (state_next != IDLE);
      done_pulse  <= (state_next == DONE);
    end
  end

endmodule
